// File: rtl/rri_pkg.sv
// Shared constants, scan FSM states and window check for the RRI histogram path.
// Latency: none (types and functions only).
// Backpressure: none.
package rri_pkg;

    localparam int unsigned NUM_BINS_DEF = 1024;
    localparam int unsigned BIN_W        = 10;
    localparam int unsigned VAL_W        = 32;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SCAN,
        DRAIN,
        ERR,
        DONE
    } scan_state_t;

    // A window is unusable if it is inverted or runs past the last bin.
    function automatic logic window_bad(input int unsigned lo,
                                        input int unsigned hi,
                                        input int unsigned num_bins);
        return (lo > hi) || (hi >= num_bins);
    endfunction

endpackage

// File: rtl/peak_tracker.sv
// Running maximum of (index, value) samples; first sample after clr loads unconditionally.
// Latency: result registered one cycle after the qualifying sample.
// Backpressure: none, accepts a sample every cycle smp_vld is high.
module peak_tracker
    import rri_pkg::*;
#(
    parameter int unsigned BIN_W = rri_pkg::BIN_W,
    parameter int unsigned VAL_W = rri_pkg::VAL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             smp_vld,
    input  logic [BIN_W-1:0] smp_idx,
    input  logic [VAL_W-1:0] smp_dat,
    output logic [BIN_W-1:0] peak_index,
    output logic [VAL_W-1:0] peak_value
);

    logic have_q;

    // Strictly-greater replace keeps the lowest index on ties, since bins arrive ascending.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            have_q     <= 1'b0;
            peak_index <= '0;
            peak_value <= '0;
        end else if (smp_vld && (!have_q || (smp_dat > peak_value))) begin
            have_q     <= 1'b1;
            peak_index <= smp_idx;
            peak_value <= smp_dat;
        end
    end

endmodule

// File: rtl/peak_scan_ctrl.sv
// Walks bin window [lo_bin..hi_bin] of the histogram RAM and reports the peak bin.
// Latency: done M+RD_LAT+2 cycles after accepted start (M = bins), k+2 on a bad window.
// Backpressure: start is ignored while busy; no stall on the RAM side.
module peak_scan_ctrl
    import rri_pkg::*;
#(
    parameter int unsigned NUM_BINS = rri_pkg::NUM_BINS_DEF,
    parameter int unsigned BIN_W    = rri_pkg::BIN_W,
    parameter int unsigned VAL_W    = rri_pkg::VAL_W,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] lo_bin,
    input  logic [BIN_W-1:0] hi_bin,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             mem_rd_en,
    output logic [BIN_W-1:0] mem_rd_addr,
    input  logic [VAL_W-1:0] mem_rd_data,
    output logic [BIN_W-1:0] peak_index,
    output logic [VAL_W-1:0] peak_value,
    output logic             peak_valid
);

    // Pipe pattern seen when only the final read is still outstanding.
    localparam logic [RD_LAT-1:0] LAST_ONLY = RD_LAT'(1) << (RD_LAT - 1);

    scan_state_t      state;
    scan_state_t      state_nxt;
    logic [BIN_W-1:0] lo_q;
    logic [BIN_W-1:0] hi_q;
    logic [BIN_W-1:0] addr_q;
    logic             peak_valid_q;
    logic             accept;
    logic [RD_LAT-1:0] rd_vld_pipe;
    logic [BIN_W-1:0] addr_pipe [RD_LAT];

    assign accept = (state == IDLE) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = CHECK;
            CHECK: state_nxt = window_bad(32'(lo_q), 32'(hi_q), NUM_BINS) ? ERR : SCAN;
            SCAN:  if (addr_q == hi_q) state_nxt = DRAIN;
            DRAIN: if (rd_vld_pipe == LAST_ONLY) state_nxt = DONE;
            ERR:   state_nxt = IDLE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lo_q         <= '0;
            hi_q         <= '0;
            addr_q       <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lo_q         <= lo_bin;
                hi_q         <= hi_bin;
                peak_valid_q <= 1'b0;
            end
            // Address only moves while reading, so it holds its last value otherwise.
            if ((state == CHECK) && (state_nxt == SCAN)) begin
                addr_q <= lo_q;
            end else if ((state == SCAN) && (addr_q != hi_q)) begin
                addr_q <= addr_q + 1'b1;
            end
            if ((state == DRAIN) && (state_nxt == DONE)) begin
                peak_valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_pipe <= '0;
        end else begin
            rd_vld_pipe[0] <= mem_rd_en;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                rd_vld_pipe[i] <= rd_vld_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        addr_pipe[0] <= addr_q;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            addr_pipe[i] <= addr_pipe[i-1];
        end
    end

    peak_tracker #(
        .BIN_W (BIN_W),
        .VAL_W (VAL_W)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .clr        (accept),
        .smp_vld    (rd_vld_pipe[RD_LAT-1]),
        .smp_idx    (addr_pipe[RD_LAT-1]),
        .smp_dat    (mem_rd_data),
        .peak_index (peak_index),
        .peak_value (peak_value)
    );

    assign busy        = (state != IDLE);
    assign done        = (state == DONE) || (state == ERR);
    assign cfg_err     = (state == ERR);
    assign mem_rd_en   = (state == SCAN);
    assign mem_rd_addr = addr_q;
    assign peak_valid  = peak_valid_q;

endmodule

// File: tb/tb_peak_scan_ctrl.sv
// Scoreboard bench for peak_scan_ctrl at RD_LAT=1 (dut 0) and RD_LAT=3 (dut 1).
// Latency: expected read/done cycles derived from window size and read latency.
// Backpressure: start pulses while busy or on the done cycle must be ignored.
module tb_peak_scan_ctrl;

    localparam int NB = 16;
    localparam int BW = 5;
    localparam int VW = 32;

    typedef struct {
        int           cyc;
        bit           err;
        int           idx;
        logic [VW-1:0] val;
    } exp_t;

    typedef struct {
        int cyc;
        int addr;
    } rd_t;

    logic          clk = 1'b0;
    int            cyc = 0;
    logic          rst [2];
    logic          start [2];
    logic [BW-1:0] lo_bin [2];
    logic [BW-1:0] hi_bin [2];
    logic          busy [2];
    logic          done [2];
    logic          cfg_err [2];
    logic          mem_rd_en [2];
    logic [BW-1:0] mem_rd_addr [2];
    logic [VW-1:0] mem_rd_data [2];
    logic [BW-1:0] peak_index [2];
    logic [VW-1:0] peak_value [2];
    logic          peak_valid [2];

    logic [VW-1:0] hist [32];
    logic [VW-1:0] ram_l1;
    logic [VW-1:0] ram_l3 [3];

    exp_t exp_q [2][$];
    rd_t  rd_q  [2][$];
    int   n_chk  = 0;
    int   n_fail = 0;

    bit            hold_known [2];
    bit            hold_valid [2];
    logic [BW-1:0] hold_idx [2];
    logic [VW-1:0] hold_val [2];
    exp_t          mon_e;
    rd_t           mon_r;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: garbage on the data bus whenever no read was issued.
    always @(posedge clk) begin
        ram_l1    <= mem_rd_en[0] ? hist[mem_rd_addr[0]] : $urandom();
        ram_l3[0] <= mem_rd_en[1] ? hist[mem_rd_addr[1]] : $urandom();
        ram_l3[1] <= ram_l3[0];
        ram_l3[2] <= ram_l3[1];
    end
    assign mem_rd_data[0] = ram_l1;
    assign mem_rd_data[1] = ram_l3[2];

    peak_scan_ctrl #(.NUM_BINS(NB), .BIN_W(BW), .VAL_W(VW), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .lo_bin(lo_bin[0]), .hi_bin(hi_bin[0]),
        .busy(busy[0]), .done(done[0]), .cfg_err(cfg_err[0]), .mem_rd_en(mem_rd_en[0]),
        .mem_rd_addr(mem_rd_addr[0]), .mem_rd_data(mem_rd_data[0]),
        .peak_index(peak_index[0]), .peak_value(peak_value[0]), .peak_valid(peak_valid[0])
    );

    peak_scan_ctrl #(.NUM_BINS(NB), .BIN_W(BW), .VAL_W(VW), .RD_LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .lo_bin(lo_bin[1]), .hi_bin(hi_bin[1]),
        .busy(busy[1]), .done(done[1]), .cfg_err(cfg_err[1]), .mem_rd_en(mem_rd_en[1]),
        .mem_rd_addr(mem_rd_addr[1]), .mem_rd_data(mem_rd_data[1]),
        .peak_index(peak_index[1]), .peak_value(peak_value[1]), .peak_valid(peak_valid[1])
    );

    function automatic void chk(input string nm, input int d, input logic [63:0] act,
                                input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d: got 0x%0h, expected 0x%0h", nm, d, cyc, act, req);
        end
    endfunction

    function automatic logic [63:0] outs(input int d);
        return {17'd0, busy[d], done[d], cfg_err[d], mem_rd_en[d], mem_rd_addr[d],
                peak_index[d], peak_value[d], peak_valid[d]};
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst[d]) begin
                if (mem_rd_en[d]) begin
                    chk("read_expected", d, 64'(rd_q[d].size() > 0), 64'd1);
                    if (rd_q[d].size() > 0) begin
                        mon_r = rd_q[d].pop_front();
                        chk("rd_cycle", d, 64'(cyc), 64'(mon_r.cyc));
                        chk("rd_addr", d, 64'(mem_rd_addr[d]), 64'(mon_r.addr));
                    end
                end
                if (cfg_err[d]) chk("cfg_err_with_done", d, 64'(done[d]), 64'd1);
                if (done[d]) begin
                    chk("done_expected", d, 64'(exp_q[d].size() > 0), 64'd1);
                    if (exp_q[d].size() > 0) begin
                        mon_e = exp_q[d].pop_front();
                        chk("done_cycle", d, 64'(cyc), 64'(mon_e.cyc));
                        chk("cfg_err", d, 64'(cfg_err[d]), 64'(mon_e.err));
                        chk("busy_at_done", d, 64'(busy[d]), 64'd1);
                        chk("peak_valid", d, 64'(peak_valid[d]), 64'(!mon_e.err));
                        if (!mon_e.err) begin
                            chk("peak_index", d, 64'(peak_index[d]), 64'(mon_e.idx));
                            chk("peak_value", d, 64'(peak_value[d]), 64'(mon_e.val));
                        end
                        hold_valid[d] = !mon_e.err;
                        hold_idx[d]   = BW'(mon_e.idx);
                        hold_val[d]   = mon_e.val;
                    end
                end else if (hold_known[d] && !busy[d]) begin
                    chk("hold_peak_valid", d, 64'(peak_valid[d]), 64'(hold_valid[d]));
                    if (hold_valid[d])
                        chk("hold_peak", d, 64'({peak_index[d], peak_value[d]}),
                            64'({hold_idx[d], hold_val[d]}));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_scan(input int d, input int lo, input int hi, output int dcyc);
        int lat;
        int best;
        int k;
        int t;
        lat = (d == 0) ? 1 : 3;
        t = 0;
        while (busy[d] && t < 100) begin
            tick();
            t++;
        end
        k = cyc;
        start[d]  = 1'b1;
        lo_bin[d] = BW'(lo);
        hi_bin[d] = BW'(hi);
        if (lo > hi || hi >= NB) begin
            dcyc = k + 2;
            exp_q[d].push_back('{dcyc, 1'b1, 0, '0});
        end else begin
            best = lo;
            for (int i = lo + 1; i <= hi; i++) if (hist[i] > hist[best]) best = i;
            for (int i = lo; i <= hi; i++) rd_q[d].push_back('{k + 2 + i - lo, i});
            dcyc = k + (hi - lo + 1) + lat + 2;
            exp_q[d].push_back('{dcyc, 1'b0, best, hist[best]});
        end
        tick();
        start[d]  = 1'b0;
        lo_bin[d] = BW'($urandom());
        hi_bin[d] = BW'($urandom());
    endtask

    task automatic finish_scan(input int d, input bit noise, input int dcyc);
        int t;
        t = 0;
        while (exp_q[d].size() != 0 && t < 200) begin
            if (noise) begin
                if (cyc == dcyc) begin
                    start[d] = 1'b1;
                end else begin
                    start[d]  = 1'($urandom_range(0, 1));
                    lo_bin[d] = BW'($urandom());
                    hi_bin[d] = BW'($urandom());
                end
            end
            tick();
            t++;
        end
        start[d] = 1'b0;
        chk("scan_completed", d, 64'(exp_q[d].size()), 64'd0);
        chk("reads_issued", d, 64'(rd_q[d].size()), 64'd0);
        exp_q[d].delete();
        rd_q[d].delete();
    endtask

    task automatic run_scan(input int d, input int lo, input int hi, input bit noise);
        int dcyc;
        issue_scan(d, lo, hi, dcyc);
        finish_scan(d, noise, dcyc);
    endtask

    initial begin
        int dc;
        int t;
        int d;
        int lo;
        int hi;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; lo_bin[i] = '0; hi_bin[i] = '0;
            hold_known[i] = 1'b0; hold_valid[i] = 1'b0; hold_idx[i] = '0; hold_val[i] = '0;
        end
        for (int i = 0; i < 32; i++) hist[i] = '0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) chk("reset_outputs", i, outs(i), 64'd0);
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0;
            hold_known[i] = 1'b1;
        end
        tick();

        for (int i = 0; i < NB; i++) hist[i] = VW'(i);
        run_scan(0, 0, 15, 1'b0);

        for (int i = 0; i < NB; i++) hist[i] = 5;
        hist[3] = 100;
        hist[9] = 100;
        run_scan(0, 0, 15, 1'b0);
        run_scan(1, 0, 15, 1'b0);

        hist[5] = 42;
        run_scan(0, 5, 5, 1'b0);
        run_scan(1, 5, 5, 1'b0);

        run_scan(0, 7, 2, 1'b0);
        run_scan(0, 0, 16, 1'b0);
        run_scan(1, 7, 2, 1'b1);

        for (int i = 0; i < NB; i++) hist[i] = VW'(i);
        issue_scan(0, 0, 15, dc);
        t = 0;
        while (rd_q[0].size() > 10 && t < 50) begin
            tick();
            t++;
        end
        rst[0] = 1'b1;
        exp_q[0].delete();
        rd_q[0].delete();
        tick();
        chk("midscan_reset_outputs", 0, outs(0), 64'd0);
        rst[0] = 1'b0;
        hold_valid[0] = 1'b0;
        repeat (10) tick();
        run_scan(0, 0, 15, 1'b0);

        for (int i = 0; i < 32; i++) hist[i] = '0;
        run_scan(0, 4, 9, 1'b1);
        run_scan(1, 4, 9, 1'b1);

        repeat (40) begin
            for (int i = 0; i < 32; i++)
                hist[i] = ($urandom_range(0, 1) == 0) ? VW'($urandom_range(0, 3)) : VW'($urandom());
            d  = int'($urandom_range(0, 1));
            lo = int'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) hi = int'($urandom_range(0, 19));
            else hi = int'($urandom_range(lo, 15));
            run_scan(d, lo, hi, 1'($urandom_range(0, 1)));
        end

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at cyc=%0d, limit=%0d", cyc, 100000);
        $fatal(1, "watchdog expired");
    end

endmodule
